// File: rtl/traffic_ctrl_n.sv
// Purpose: N-way traffic light controller; round-robin GREEN -> YELLOW -> ALL_RED arbitration over level requests.
// Latency: every output is registered; a green-exit decision made at a clock edge is visible from that edge onward.
// Backpressure: none; requests are level-sensitive and must stay high until served, the latched target is never revoked.
module traffic_ctrl_n #(
    parameter int N_WAYS      = 4,
    parameter int CNT_W       = 8,
    parameter int MIN_GREEN   = 4,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_WAYS-1:0]         req,
    input  logic                      auto_mode,
    output logic [N_WAYS-1:0]         light_en,
    output logic [N_WAYS-1:0]         yellow_en,
    output logic [$clog2(N_WAYS)-1:0] active_way,
    output logic [CNT_W-1:0]          counter_out
);

    localparam int AW = $clog2(N_WAYS);

    // Dwell thresholds expressed in counter units (counter is 0 on the first cycle of a state)
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [AW-1:0]     active_q;
    logic [AW-1:0]     active_d;
    logic [AW-1:0]     target_q;
    logic [N_WAYS-1:0] light_q;
    logic [N_WAYS-1:0] yellow_q;
    logic [N_WAYS-1:0] light_d;
    logic [N_WAYS-1:0] yellow_d;

    logic [N_WAYS-1:0] eff_req;
    logic [N_WAYS-1:0] masked_req;
    logic              scan_hit;
    logic [AW-1:0]     scan_way;
    int                scan_idx;

    logic              green_done;
    logic              yellow_done;
    logic              allred_done;
    logic              state_change;

    function automatic logic [N_WAYS-1:0] onehot(input logic [AW-1:0] idx);
        logic [N_WAYS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Requests seen by the arbiter: auto mode asks for every way; the current way never competes with itself
    always_comb begin
        eff_req    = auto_mode ? {N_WAYS{1'b1}} : req;
        masked_req = eff_req & ~onehot(active_q);
    end

    // Round-robin scan from active+1 upward with wrap; walking far-to-near lets the nearest hit win
    always_comb begin
        scan_hit = 1'b0;
        scan_way = active_q;
        scan_idx = 0;
        for (int i = N_WAYS - 1; i >= 1; i--) begin
            scan_idx = int'(active_q) + i;
            if (scan_idx >= N_WAYS) begin
                scan_idx = scan_idx - N_WAYS;
            end
            if (masked_req[scan_idx]) begin
                scan_hit = 1'b1;
                scan_way = AW'(scan_idx);
            end
        end
    end

    // Dwell-complete flags for each state
    always_comb begin
        green_done  = (cnt_q >= GREEN_LAST);
        yellow_done = (cnt_q == YELLOW_LAST);
        allred_done = (cnt_q == ALLRED_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GREEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: green holds until its minimum dwell has elapsed and another way is waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GREEN:  if (green_done && scan_hit) state_d = ST_YELLOW;
            ST_YELLOW: if (yellow_done)            state_d = ST_ALLRED;
            ST_ALLRED: if (allred_done)            state_d = ST_GREEN;
            default:                               state_d = ST_GREEN;
        endcase
    end

    assign state_change = (state_d != state_q);

    // Dwell counter restarts on every state entry and saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_change) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Target is frozen at the green exit so later request changes cannot redirect the transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
        end else if (state_q == ST_GREEN && state_d == ST_YELLOW) begin
            target_q <= scan_way;
        end
    end

    // Active way hands over to the latched target when all-red clearance ends
    always_comb begin
        active_d = active_q;
        if (state_q == ST_ALLRED && allred_done) begin
            active_d = target_q;
        end
    end

    // Active way register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
        end else begin
            active_q <= active_d;
        end
    end

    // Output decode from the upcoming state so the lamp registers line up with the state register
    always_comb begin
        light_d  = '0;
        yellow_d = '0;
        case (state_d)
            ST_GREEN:  light_d  = onehot(active_d);
            ST_YELLOW: yellow_d = onehot(active_d);
            default: begin
                light_d  = '0;
                yellow_d = '0;
            end
        endcase
    end

    // Lamp registers; reset shows way 0 green
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_q  <= {{(N_WAYS-1){1'b0}}, 1'b1};
            yellow_q <= '0;
        end else begin
            light_q  <= light_d;
            yellow_q <= yellow_d;
        end
    end

    assign light_en    = light_q;
    assign yellow_en   = yellow_q;
    assign active_way  = active_q;
    assign counter_out = cnt_q;

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 Parameter N_WAYS, default 4: number of approach ways; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of counter_out.
REQ-003 Parameter MIN_GREEN, default 4: minimum green dwell in cycles; legal range 1..2^CNT_W-1.
REQ-004 Parameter YELLOW_TIME, default 2: yellow dwell in cycles; legal range 1..2^CNT_W-1.
REQ-005 Parameter ALLRED_TIME, default 1: all-red clearance dwell in cycles; legal range 1..2^CNT_W-1.
REQ-006 clk  input  1: single clock; all state updates occur on its rising edge.
REQ-007 rst_n  input  1: reset, asynchronous and active-low.
REQ-008 req  input  N_WAYS: level-sensitive request per way; bit i means way i wants green.
REQ-009 auto_mode  input  1: when 1, every way is treated as requesting (fixed round-robin cycling).
REQ-010 light_en  output  N_WAYS: one-hot green enable; bit i high means way i is green.
REQ-011 yellow_en  output  N_WAYS: one-hot yellow enable for the way currently clearing.
REQ-012 active_way  output  $clog2(N_WAYS): index of the way currently holding or leaving green.
REQ-013 counter_out  output  CNT_W: cycles spent in the current state.

Function
REQ-014 FSM states: GREEN, YELLOW, ALL_RED; the encoding is internal.
REQ-015 counter_out SHALL be 0 on the first cycle of every state entry, increment by 1 each cycle after, and saturate at 2^CNT_W-1 with no wrap.
REQ-016 Effective request vector eff_req = auto_mode ? all-ones : req; the bit of active_way is masked out of eff_req.
REQ-017 GREEN -> YELLOW when counter_out >= MIN_GREEN-1 and masked eff_req is non-zero; otherwise remain in GREEN indefinitely.
REQ-018 On the GREEN->YELLOW edge, a target way SHALL be latched: the first set bit of masked eff_req searching from active_way+1 upward, wrapping modulo N_WAYS.
REQ-019 YELLOW -> ALL_RED when counter_out == YELLOW_TIME-1.
REQ-020 ALL_RED -> GREEN when counter_out == ALLRED_TIME-1; on that edge active_way SHALL load the latched target.
REQ-021 In GREEN, light_en = onehot(active_way) and yellow_en = 0; in YELLOW, light_en = 0 and yellow_en = onehot(active_way); in ALL_RED, both are 0.
REQ-022 At most one bit across light_en|yellow_en SHALL be high in any cycle.
REQ-023 Requests deasserted or changed after the latch in REQ-018 SHALL NOT alter the latched target; the transition completes.
REQ-024 A request for active_way alone SHALL never cause a transition.
REQ-025 Simultaneous requests from multiple ways SHALL be served in round-robin order starting from active_way+1.
REQ-026 A change of auto_mode takes effect at the next GREEN exit decision only.
REQ-027 All outputs SHALL be driven directly from registers (no combinational path from req or auto_mode to outputs).

Reset
REQ-028 While rst_n = 0: state GREEN, active_way = 0, light_en = 1 (way 0 green), yellow_en = 0, counter_out = 0, latched target = 0.
REQ-029 rst_n assertion mid-operation SHALL force the reset values immediately, without waiting for a clock edge.
REQ-030 Counting SHALL begin on the first rising edge after rst_n deasserts.

Verification
REQ-031 Defaults; release reset, req = 0, auto_mode = 0 for 20 cycles -> way 0 stays green, counter_out saturates only at 255, yellow_en = 0.
REQ-032 Defaults; req = 4'b0010 from cycle 0 -> way 0 green cycles 0-3, yellow_en = 4'b0001 cycles 4-5, all-off cycle 6, light_en = 4'b0010 at cycle 7.
REQ-033 In way-1 green, req = 4'b1001 -> next green is way 3; after its MIN_GREEN, with req = 4'b1001 still held, next green is way 0.
REQ-034 auto_mode = 1, req = 0 -> greens cycle 0,1,2,3,0, each green lasting 4 cycles with a 7-cycle period per way.
REQ-035 req = 4'b0100 latched, then req dropped to 0 during YELLOW -> way 2 still becomes green; rst_n pulsed low mid-YELLOW -> light_en = 4'b0001 and counter_out = 0 asynchronously.
REQ-036 N_WAYS = 2, CNT_W = 3, MIN_GREEN = 7, auto_mode = 1 -> counter_out reaches 6, ways alternate, no one-hot violation.
